rv32i_decoder: RTL and testbench

- Registered RV32I instruction decoder.
- Sits between the instruction-fetch stage and the issue logic (ROB/RS/LSB).
- Takes one 32-bit instruction word plus a valid strobe and produces, one cycle later:
  - an internal 6-bit opcode
  - 6-bit register tags for rd/rs1/rs2
  - the sign-extended immediate
  - a load/store flag

---
 rtl/rv32i_decoder.sv | 294 +++++++++++++++++++++++++++++
 tb/tb_rv32i_decoder.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/rv32i_decoder.sv
// ---------------------------------------------------------------------------
// rv32i_decoder
// Registered RV32I instruction decoder between instruction fetch and issue.
// Each accepted instruction appears on the outputs one clock later, decoded
// into an internal opcode, register tags, a sign-extended immediate and a
// load/store flag.
//
// Ports:
//   clk           in   1   system clock, rising edge
//   rst           in   1   asynchronous active-high reset
//   inst_valid    in   1   inst holds a fetched instruction this cycle
//   inst          in  32   raw RV32I instruction word
//   out_valid     out  1   decoded fields are valid (registered)
//   op            out  6   internal opcode (0 = INVALID)
//   rd            out  6   destination tag, or NO_REG (32)
//   rs1           out  6   source 1 tag, or NO_REG
//   rs2           out  6   source 2 tag, or NO_REG
//   imm           out 32   decoded immediate
//   is_load_store out  1   op is one of LB..SW
// ---------------------------------------------------------------------------
module rv32i_decoder #(
    parameter logic [5:0] NO_REG = 6'd32
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        inst_valid,
    input  logic [31:0] inst,
    output logic        out_valid,
    output logic [5:0]  op,
    output logic [5:0]  rd,
    output logic [5:0]  rs1,
    output logic [5:0]  rs2,
    output logic [31:0] imm,
    output logic        is_load_store
);

    // Internal opcode encoding; branches 5..10 and loads/stores 11..18 are
    // kept contiguous so downstream range checks stay cheap.
    localparam logic [5:0] OP_INVALID = 6'd0;
    localparam logic [5:0] OP_LUI     = 6'd1;
    localparam logic [5:0] OP_AUIPC   = 6'd2;
    localparam logic [5:0] OP_JAL     = 6'd3;
    localparam logic [5:0] OP_JALR    = 6'd4;
    localparam logic [5:0] OP_BEQ     = 6'd5;
    localparam logic [5:0] OP_BNE     = 6'd6;
    localparam logic [5:0] OP_BLT     = 6'd7;
    localparam logic [5:0] OP_BGE     = 6'd8;
    localparam logic [5:0] OP_BLTU    = 6'd9;
    localparam logic [5:0] OP_BGEU    = 6'd10;
    localparam logic [5:0] OP_LB      = 6'd11;
    localparam logic [5:0] OP_LH      = 6'd12;
    localparam logic [5:0] OP_LW      = 6'd13;
    localparam logic [5:0] OP_LBU     = 6'd14;
    localparam logic [5:0] OP_LHU     = 6'd15;
    localparam logic [5:0] OP_SB      = 6'd16;
    localparam logic [5:0] OP_SH      = 6'd17;
    localparam logic [5:0] OP_SW      = 6'd18;
    localparam logic [5:0] OP_ADDI    = 6'd19;
    localparam logic [5:0] OP_SLTI    = 6'd20;
    localparam logic [5:0] OP_SLTIU   = 6'd21;
    localparam logic [5:0] OP_XORI    = 6'd22;
    localparam logic [5:0] OP_ORI     = 6'd23;
    localparam logic [5:0] OP_ANDI    = 6'd24;
    localparam logic [5:0] OP_SLLI    = 6'd25;
    localparam logic [5:0] OP_SRLI    = 6'd26;
    localparam logic [5:0] OP_SRAI    = 6'd27;
    localparam logic [5:0] OP_ADD     = 6'd28;
    localparam logic [5:0] OP_SUB     = 6'd29;
    localparam logic [5:0] OP_SLL     = 6'd30;
    localparam logic [5:0] OP_SLT     = 6'd31;
    localparam logic [5:0] OP_SLTU    = 6'd32;
    localparam logic [5:0] OP_XOR     = 6'd33;
    localparam logic [5:0] OP_SRL     = 6'd34;
    localparam logic [5:0] OP_SRA     = 6'd35;
    localparam logic [5:0] OP_OR      = 6'd36;
    localparam logic [5:0] OP_AND     = 6'd37;

    // Instruction formats; FMT_SH is OP-IMM shifts with a zero-extended shamt.
    localparam logic [2:0] FMT_NONE = 3'd0;
    localparam logic [2:0] FMT_R    = 3'd1;
    localparam logic [2:0] FMT_I    = 3'd2;
    localparam logic [2:0] FMT_S    = 3'd3;
    localparam logic [2:0] FMT_B    = 3'd4;
    localparam logic [2:0] FMT_U    = 3'd5;
    localparam logic [2:0] FMT_J    = 3'd6;
    localparam logic [2:0] FMT_SH   = 3'd7;

    localparam logic [6:0] F7_ZERO = 7'b0000000;
    localparam logic [6:0] F7_ALT  = 7'b0100000;

    logic [6:0]  opcode_s;
    logic [2:0]  funct3_s;
    logic [6:0]  funct7_s;
    logic [5:0]  op_s;
    logic [2:0]  fmt_raw_s;
    logic [2:0]  fmt_s;
    logic [5:0]  rd_s;
    logic [5:0]  rs1_s;
    logic [5:0]  rs2_s;
    logic [31:0] imm_s;
    logic        ls_s;

    assign opcode_s = inst[6:0];
    assign funct3_s = inst[14:12];
    assign funct7_s = inst[31:25];

    // Opcode/funct3/funct7 to internal opcode; fmt_raw_s follows the major opcode only.
    always_comb begin
        op_s      = OP_INVALID;
        fmt_raw_s = FMT_NONE;
        case (opcode_s)
            7'b0110111: begin op_s = OP_LUI;   fmt_raw_s = FMT_U; end
            7'b0010111: begin op_s = OP_AUIPC; fmt_raw_s = FMT_U; end
            7'b1101111: begin op_s = OP_JAL;   fmt_raw_s = FMT_J; end
            7'b1100111: begin
                fmt_raw_s = FMT_I;
                if (funct3_s == 3'b000) begin
                    op_s = OP_JALR;
                end else begin
                    op_s = OP_INVALID;
                end
            end
            7'b1100011: begin
                fmt_raw_s = FMT_B;
                case (funct3_s)
                    3'b000:  op_s = OP_BEQ;
                    3'b001:  op_s = OP_BNE;
                    3'b100:  op_s = OP_BLT;
                    3'b101:  op_s = OP_BGE;
                    3'b110:  op_s = OP_BLTU;
                    3'b111:  op_s = OP_BGEU;
                    default: op_s = OP_INVALID;
                endcase
            end
            7'b0000011: begin
                fmt_raw_s = FMT_I;
                case (funct3_s)
                    3'b000:  op_s = OP_LB;
                    3'b001:  op_s = OP_LH;
                    3'b010:  op_s = OP_LW;
                    3'b100:  op_s = OP_LBU;
                    3'b101:  op_s = OP_LHU;
                    default: op_s = OP_INVALID;
                endcase
            end
            7'b0100011: begin
                fmt_raw_s = FMT_S;
                case (funct3_s)
                    3'b000:  op_s = OP_SB;
                    3'b001:  op_s = OP_SH;
                    3'b010:  op_s = OP_SW;
                    default: op_s = OP_INVALID;
                endcase
            end
            7'b0010011: begin
                fmt_raw_s = FMT_I;
                case (funct3_s)
                    3'b000:  op_s = OP_ADDI;
                    3'b010:  op_s = OP_SLTI;
                    3'b011:  op_s = OP_SLTIU;
                    3'b100:  op_s = OP_XORI;
                    3'b110:  op_s = OP_ORI;
                    3'b111:  op_s = OP_ANDI;
                    3'b001:  op_s = (funct7_s == F7_ZERO) ? OP_SLLI : OP_INVALID;
                    3'b101: begin
                        if (funct7_s == F7_ZERO) begin
                            op_s = OP_SRLI;
                        end else if (funct7_s == F7_ALT) begin
                            op_s = OP_SRAI;
                        end else begin
                            op_s = OP_INVALID;
                        end
                    end
                    default: op_s = OP_INVALID;
                endcase
            end
            7'b0110011: begin
                fmt_raw_s = FMT_R;
                // funct7 only disambiguates ADD/SUB and SRL/SRA; other
                // funct3 values accept any funct7.
                case (funct3_s)
                    3'b000: begin
                        if (funct7_s == F7_ZERO) begin
                            op_s = OP_ADD;
                        end else if (funct7_s == F7_ALT) begin
                            op_s = OP_SUB;
                        end else begin
                            op_s = OP_INVALID;
                        end
                    end
                    3'b101: begin
                        if (funct7_s == F7_ZERO) begin
                            op_s = OP_SRL;
                        end else if (funct7_s == F7_ALT) begin
                            op_s = OP_SRA;
                        end else begin
                            op_s = OP_INVALID;
                        end
                    end
                    3'b001:  op_s = OP_SLL;
                    3'b010:  op_s = OP_SLT;
                    3'b011:  op_s = OP_SLTU;
                    3'b100:  op_s = OP_XOR;
                    3'b110:  op_s = OP_OR;
                    3'b111:  op_s = OP_AND;
                    default: op_s = OP_INVALID;
                endcase
            end
            default: begin
                op_s      = OP_INVALID;
                fmt_raw_s = FMT_NONE;
            end
        endcase
    end

    // An invalid combination drops to FMT_NONE so every field reads as empty.
    assign fmt_s = (op_s == OP_INVALID) ? FMT_NONE :
                   ((op_s >= OP_SLLI) && (op_s <= OP_SRAI)) ? FMT_SH : fmt_raw_s;

    assign ls_s = (op_s >= OP_LB) && (op_s <= OP_SW);

    // Register tags and immediate selected by instruction format.
    always_comb begin
        rd_s  = NO_REG;
        rs1_s = NO_REG;
        rs2_s = NO_REG;
        imm_s = 32'd0;
        case (fmt_s)
            FMT_R: begin
                rd_s  = {1'b0, inst[11:7]};
                rs1_s = {1'b0, inst[19:15]};
                rs2_s = {1'b0, inst[24:20]};
            end
            FMT_I: begin
                rd_s  = {1'b0, inst[11:7]};
                rs1_s = {1'b0, inst[19:15]};
                imm_s = {{20{inst[31]}}, inst[31:20]};
            end
            FMT_SH: begin
                rd_s  = {1'b0, inst[11:7]};
                rs1_s = {1'b0, inst[19:15]};
                imm_s = {27'd0, inst[24:20]};
            end
            FMT_S: begin
                rs1_s = {1'b0, inst[19:15]};
                rs2_s = {1'b0, inst[24:20]};
                imm_s = {{20{inst[31]}}, inst[31:25], inst[11:7]};
            end
            FMT_B: begin
                rs1_s = {1'b0, inst[19:15]};
                rs2_s = {1'b0, inst[24:20]};
                imm_s = {{19{inst[31]}}, inst[31], inst[7], inst[30:25], inst[11:8], 1'b0};
            end
            FMT_U: begin
                rd_s  = {1'b0, inst[11:7]};
                imm_s = {inst[31:12], 12'd0};
            end
            FMT_J: begin
                rd_s  = {1'b0, inst[11:7]};
                imm_s = {{11{inst[31]}}, inst[31], inst[19:12], inst[20], inst[30:21], 1'b0};
            end
            default: begin
                rd_s  = NO_REG;
                rs1_s = NO_REG;
                rs2_s = NO_REG;
                imm_s = 32'd0;
            end
        endcase
    end

    // Output register: fields load only on accepted instructions and hold otherwise.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid     <= 1'b0;
            op            <= OP_INVALID;
            rd            <= NO_REG;
            rs1           <= NO_REG;
            rs2           <= NO_REG;
            imm           <= 32'd0;
            is_load_store <= 1'b0;
        end else begin
            out_valid <= inst_valid;
            if (inst_valid) begin
                op            <= op_s;
                rd            <= rd_s;
                rs1           <= rs1_s;
                rs2           <= rs2_s;
                imm           <= imm_s;
                is_load_store <= ls_s;
            end
        end
    end

endmodule

// File: tb/tb_rv32i_decoder.sv
module tb_rv32i_decoder;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        inst_valid = 1'b0;
    logic [31:0] inst = 32'd0;
    logic        out_valid;
    logic [5:0]  op, rd, rs1, rs2;
    logic [31:0] imm;
    logic        is_load_store;

    rv32i_decoder dut (
        .clk(clk), .rst(rst), .inst_valid(inst_valid), .inst(inst),
        .out_valid(out_valid), .op(op), .rd(rd), .rs1(rs1), .rs2(rs2),
        .imm(imm), .is_load_store(is_load_store)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [5:0]  op, rd, rs1, rs2;
        logic [31:0] imm;
        logic        ls;
        int          cyc;
    } exp_t;

    // Instruction pattern table: format 0=R 1=I 2=S 3=B 4=U 5=J 6=shift-imm
    typedef struct {
        logic [31:0] mask;
        logic [31:0] match;
        int          opc;
        int          fmt;
    } pat_t;

    pat_t tbl[$];
    exp_t q[$];
    exp_t last;
    exp_t mon_e;
    logic mon_expv;
    int   cyc = 0;
    int   total = 0;
    int   bad = 0;

    always @(posedge clk) cyc++;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, req, $time);
        end
    endtask

    function automatic exp_t mk(int o, int d, int s1, int s2, logic [31:0] im);
        exp_t e;
        e.op = 6'(o); e.rd = 6'(d); e.rs1 = 6'(s1); e.rs2 = 6'(s2); e.imm = im;
        e.ls = (o >= 11 && o <= 18);
        e.cyc = 0;
        return e;
    endfunction

    task automatic add(input logic [31:0] m, input logic [31:0] v, input int o, input int f);
        pat_t p;
        p.mask = m; p.match = v; p.opc = o; p.fmt = f;
        tbl.push_back(p);
    endtask

    task automatic build_table();
        add(32'h0000007F, 32'h00000037, 1, 4);
        add(32'h0000007F, 32'h00000017, 2, 4);
        add(32'h0000007F, 32'h0000006F, 3, 5);
        add(32'h0000707F, 32'h00000067, 4, 1);
        add(32'h0000707F, 32'h00000063, 5, 3);
        add(32'h0000707F, 32'h00001063, 6, 3);
        add(32'h0000707F, 32'h00004063, 7, 3);
        add(32'h0000707F, 32'h00005063, 8, 3);
        add(32'h0000707F, 32'h00006063, 9, 3);
        add(32'h0000707F, 32'h00007063, 10, 3);
        add(32'h0000707F, 32'h00000003, 11, 1);
        add(32'h0000707F, 32'h00001003, 12, 1);
        add(32'h0000707F, 32'h00002003, 13, 1);
        add(32'h0000707F, 32'h00004003, 14, 1);
        add(32'h0000707F, 32'h00005003, 15, 1);
        add(32'h0000707F, 32'h00000023, 16, 2);
        add(32'h0000707F, 32'h00001023, 17, 2);
        add(32'h0000707F, 32'h00002023, 18, 2);
        add(32'h0000707F, 32'h00000013, 19, 1);
        add(32'h0000707F, 32'h00002013, 20, 1);
        add(32'h0000707F, 32'h00003013, 21, 1);
        add(32'h0000707F, 32'h00004013, 22, 1);
        add(32'h0000707F, 32'h00006013, 23, 1);
        add(32'h0000707F, 32'h00007013, 24, 1);
        add(32'hFE00707F, 32'h00001013, 25, 6);
        add(32'hFE00707F, 32'h00005013, 26, 6);
        add(32'hFE00707F, 32'h40005013, 27, 6);
        add(32'hFE00707F, 32'h00000033, 28, 0);
        add(32'hFE00707F, 32'h40000033, 29, 0);
        add(32'h0000707F, 32'h00001033, 30, 0);
        add(32'h0000707F, 32'h00002033, 31, 0);
        add(32'h0000707F, 32'h00003033, 32, 0);
        add(32'h0000707F, 32'h00004033, 33, 0);
        add(32'hFE00707F, 32'h00005033, 34, 0);
        add(32'hFE00707F, 32'h40005033, 35, 0);
        add(32'h0000707F, 32'h00006033, 36, 0);
        add(32'h0000707F, 32'h00007033, 37, 0);
    endtask

    // Reference model: first matching pattern decides opcode and format.
    function automatic exp_t model(logic [31:0] w);
        exp_t e;
        int d, s1, s2;
        logic signed [11:0] i12;
        logic signed [12:0] b13;
        logic signed [20:0] j21;
        e = mk(0, 32, 32, 32, 32'd0);
        d = int'(w[11:7]); s1 = int'(w[19:15]); s2 = int'(w[24:20]);
        foreach (tbl[k]) begin
            if ((w & tbl[k].mask) == tbl[k].match) begin
                case (tbl[k].fmt)
                    0: e = mk(tbl[k].opc, d, s1, s2, 32'd0);
                    1: begin i12 = w[31:20]; e = mk(tbl[k].opc, d, s1, 32, 32'(int'(i12))); end
                    2: begin i12 = {w[31:25], w[11:7]}; e = mk(tbl[k].opc, 32, s1, s2, 32'(int'(i12))); end
                    3: begin b13 = {w[31], w[7], w[30:25], w[11:8], 1'b0};
                              e = mk(tbl[k].opc, 32, s1, s2, 32'(int'(b13))); end
                    4: e = mk(tbl[k].opc, d, 32, 32, w & 32'hFFFFF000);
                    5: begin j21 = {w[31], w[19:12], w[20], w[30:21], 1'b0};
                              e = mk(tbl[k].opc, d, 32, 32, 32'(int'(j21))); end
                    default: e = mk(tbl[k].opc, d, s1, 32, 32'(s2));
                endcase
                break;
            end
        end
        return e;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic v, input logic [31:0] w, input exp_t e);
        inst_valid = v;
        inst = w;
        if (v) begin
            e.cyc = cyc;
            q.push_back(e);
        end
        tick();
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_valid"}, {31'd0, out_valid}, 32'd0);
        chk({tag, "_op"}, {26'd0, op}, 32'd0);
        chk({tag, "_rd"}, {26'd0, rd}, 32'd32);
        chk({tag, "_rs1"}, {26'd0, rs1}, 32'd32);
        chk({tag, "_rs2"}, {26'd0, rs2}, 32'd32);
        chk({tag, "_imm"}, imm, 32'd0);
        chk({tag, "_ls"}, {31'd0, is_load_store}, 32'd0);
    endtask

    // Monitor: pops expected results when the DUT presents one, checks hold otherwise.
    always @(negedge clk) begin
        if (!rst) begin
            mon_expv = (q.size() > 0) && (q[0].cyc + 1 == cyc);
            chk("out_valid", {31'd0, out_valid}, {31'd0, mon_expv});
            if (out_valid && mon_expv) begin
                mon_e = q.pop_front();
                chk("op", {26'd0, op}, {26'd0, mon_e.op});
                chk("rd", {26'd0, rd}, {26'd0, mon_e.rd});
                chk("rs1", {26'd0, rs1}, {26'd0, mon_e.rs1});
                chk("rs2", {26'd0, rs2}, {26'd0, mon_e.rs2});
                chk("imm", imm, mon_e.imm);
                chk("is_load_store", {31'd0, is_load_store}, {31'd0, mon_e.ls});
                last = mon_e;
            end else if (!out_valid) begin
                chk("hold_op", {26'd0, op}, {26'd0, last.op});
                chk("hold_rd", {26'd0, rd}, {26'd0, last.rd});
                chk("hold_rs1", {26'd0, rs1}, {26'd0, last.rs1});
                chk("hold_rs2", {26'd0, rs2}, {26'd0, last.rs2});
                chk("hold_imm", imm, last.imm);
                chk("hold_ls", {31'd0, is_load_store}, {31'd0, last.ls});
            end
        end
    end

    exp_t nil;

    initial begin
        logic [31:0] w;
        pat_t p;
        build_table();
        nil = mk(0, 32, 32, 32, 32'd0);
        last = nil;

        // Reset state while reset is held
        #12;
        chk_reset_vals("reset");
        rst = 1'b0;
        issue(1'b0, 32'd0, nil);

        // Directed decodes with hand-derived expectations
        issue(1'b1, 32'h00500093, mk(19, 1, 0, 32, 32'd5));
        issue(1'b0, 32'd0, nil);
        issue(1'b1, 32'hFE208CE3, mk(5, 32, 1, 2, 32'hFFFFFFF8));
        issue(1'b1, 32'h00512623, mk(18, 32, 2, 5, 32'd12));
        issue(1'b1, 32'h123451B7, mk(1, 3, 32, 32, 32'h12345000));
        issue(1'b1, 32'h40325213, mk(27, 4, 4, 32, 32'd3));
        issue(1'b1, 32'hFFFFFFFF, nil);
        issue(1'b0, 32'd0, nil);
        issue(1'b0, 32'd0, nil);
        issue(1'b1, 32'h0000006F, mk(3, 0, 32, 32, 32'd0));
        issue(1'b1, 32'h00209033, mk(30, 0, 1, 2, 32'd0));
        issue(1'b1, 32'h02209013, nil);
        issue(1'b0, 32'd0, nil);

        // Asynchronous reset in the middle of a decoded result
        issue(1'b1, 32'h00A00113, mk(19, 2, 0, 32, 32'd10));
        #2;
        rst = 1'b1;
        q.delete();
        last = nil;
        #1;
        chk_reset_vals("async_reset");
        inst_valid = 1'b0;
        #3;
        rst = 1'b0;
        tick();
        chk("post_reset_valid", {31'd0, out_valid}, 32'd0);

        // Randomized stream against the reference model
        for (int n = 0; n < 2000; n++) begin
            if ($urandom_range(0, 4) == 0) begin
                w = $urandom;
            end else begin
                p = tbl[$urandom_range(0, tbl.size() - 1)];
                w = ($urandom & ~p.mask) | p.match;
                if ($urandom_range(0, 9) == 0) w = w ^ (32'h1 << $urandom_range(25, 31));
            end
            issue($urandom_range(0, 3) != 0, w, model(w));
        end
        issue(1'b0, 32'd0, nil);

        // Drain with a bounded wait
        for (int k = 0; k < 20 && q.size() > 0; k++) tick();
        chk("drain_empty", 32'(q.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
